// File: rtl/gpu_def_pkg.sv
// Shared GPU memory-port definitions: the command bundle that every requester
// and the DDR-side port exchange, plus the transfer size encodings.
package gpu_def;

   localparam logic [1:0] MEM_SIZE_8B  = 2'd0;
   localparam logic [1:0] MEM_SIZE_32B = 2'd1;

   typedef struct packed {
      logic [1:0]   size;
      logic         write;
      logic [14:0]  adr;
      logic [2:0]   subadr;
      logic [15:0]  mask;
      logic [255:0] data;
   } mem_cmd_t;

endpackage

// File: rtl/gpu_mem_fifo.sv
// Small in-order FIFO holding the owner index of each outstanding read.
// The head is readable combinationally so a return can be steered in the same cycle.
module gpu_mem_fifo #(
   parameter int WIDTH  = 2,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   output logic             o_accept,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_popData
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              do_push, do_pop;

   assign o_valid   = (count_q != '0);
   assign o_popData = mem_q[rd_ptr_q];
   // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
   assign o_accept  = (count_q != (ADDR_W+1)'(DEPTH)) || i_pop;
   assign do_pop    = i_pop && o_valid;
   assign do_push   = i_push && o_accept;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_pushData;
      end
   end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Shares the DDR command port between GPU requesters with round-robin plus lock,
// and steers read returns back to their issuer through an in-order owner FIFO.
module gpu_mem_arbiter
   import gpu_def::*;
#(
   parameter int NREQ      = 4,
   parameter int TAG_DEPTH = 4,
   parameter int TAG_AW    = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NREQ-1:0]     i_reqCommand,
   output logic [NREQ-1:0]     o_reqBusy,
   input  logic [NREQ-1:0]     i_reqLock,
   input  logic [2*NREQ-1:0]   i_reqCommandSize,
   input  logic [NREQ-1:0]     i_reqWrite,
   input  logic [15*NREQ-1:0]  i_reqAdr,
   input  logic [3*NREQ-1:0]   i_reqSubadr,
   input  logic [16*NREQ-1:0]  i_reqWriteMask,
   input  logic [256*NREQ-1:0] i_reqDataOut,
   output logic [NREQ-1:0]     o_reqDataInValid,
   output logic [255:0]        o_reqDataIn,
   output logic                o_command,
   input  logic                i_busy,
   output logic [1:0]          o_commandSize,
   output logic                o_write,
   output logic [14:0]         o_adr,
   output logic [2:0]          o_subadr,
   output logic [15:0]         o_writeMask,
   output logic [255:0]        o_dataOut,
   input  logic [255:0]        i_dataIn,
   input  logic                i_dataInValid,
   output logic                o_readPending,
   output logic                o_errUnexpectedData
);

   localparam int REQ_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [REQ_W-1:0] lock_owner_q, lock_owner_d;
   logic             lock_valid_q, lock_valid_d;
   logic             err_q, err_d;

   mem_cmd_t         req_cmd [NREQ];
   mem_cmd_t         win_cmd;
   logic [NREQ-1:0]  eligible;
   logic [REQ_W:0]   pick;
   logic             win_valid;
   logic [REQ_W-1:0] win_idx;
   logic             grant, transfer;
   logic             tag_accept, tag_valid, tag_push, tag_pop;
   logic [REQ_W-1:0] tag_head;

   // First eligible index at or after ptr, wrapping; MSB flags that one was found.
   function automatic logic [REQ_W:0] rr_pick(input logic [NREQ-1:0] elig,
                                               input logic [REQ_W-1:0] ptr);
      logic             found;
      logic [REQ_W-1:0] idx;
      int               k;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(ptr) + i) % NREQ;
         if (!found && elig[k]) begin
            found = 1'b1;
            idx   = REQ_W'(k);
         end
      end
      return {found, idx};
   endfunction

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_cmd[gi] = {i_reqCommandSize[2*gi +: 2], i_reqWrite[gi],
                            i_reqAdr[15*gi +: 15], i_reqSubadr[3*gi +: 3],
                            i_reqWriteMask[16*gi +: 16], i_reqDataOut[256*gi +: 256]};
      // Reads need a free owner slot; writes never wait on the FIFO.
      assign eligible[gi] = i_reqCommand[gi] && (req_cmd[gi].write || tag_accept);
      assign o_reqBusy[gi] = !(grant && (win_idx == REQ_W'(gi)) && !i_busy);
      assign o_reqDataInValid[gi] = tag_pop && (tag_head == REQ_W'(gi));
   end

   always_comb begin
      pick = rr_pick(eligible, rr_ptr_q);
      if (lock_valid_q) begin
         // A held lock reserves the port even when its owner is idle.
         win_valid = eligible[lock_owner_q];
         win_idx   = lock_owner_q;
      end else begin
         win_valid = pick[REQ_W];
         win_idx   = pick[REQ_W-1:0];
      end
   end

   assign grant    = win_valid && !i_rst;
   assign transfer = grant && !i_busy;
   assign win_cmd  = grant ? req_cmd[win_idx] : '0;
   assign tag_push = transfer && !win_cmd.write;
   assign tag_pop  = i_dataInValid && tag_valid && !i_rst;

   assign o_command     = grant;
   assign o_commandSize = win_cmd.size;
   assign o_write       = win_cmd.write;
   assign o_adr         = win_cmd.adr;
   assign o_subadr      = win_cmd.subadr;
   assign o_writeMask   = win_cmd.mask;
   assign o_dataOut     = win_cmd.data;

   assign o_reqDataIn         = i_rst ? '0 : i_dataIn;
   assign o_readPending       = tag_valid && !i_rst;
   assign o_errUnexpectedData = err_q && !i_rst;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_owner_d = lock_owner_q;
      lock_valid_d = lock_valid_q;
      err_d        = err_q || (i_dataInValid && !tag_valid);
      if (transfer) begin
         rr_ptr_d     = (win_idx == REQ_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
         lock_valid_d = i_reqLock[win_idx];
         lock_owner_d = win_idx;
      end else if (lock_valid_q && !i_reqLock[lock_owner_q]) begin
         lock_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr_q     <= '0;
         lock_owner_q <= '0;
         lock_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_owner_q <= lock_owner_d;
         lock_valid_q <= lock_valid_d;
         err_q        <= err_d;
      end
   end

   gpu_mem_fifo #(
      .WIDTH  (REQ_W),
      .DEPTH  (TAG_DEPTH),
      .ADDR_W (TAG_AW)
   ) u_owner_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (tag_push),
      .i_pushData (win_idx),
      .o_accept   (tag_accept),
      .i_pop      (tag_pop),
      .o_valid    (tag_valid),
      .o_popData  (tag_head)
   );

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Random requester/memory traffic checked every cycle against a queue-based
// reference of the arbitration, lock and read-return rules.
module tb_gpu_mem_arbiter;

   localparam int NREQ      = 4;
   localparam int TAG_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_cmd, req_busy, req_lock, req_write, req_dv;
   logic [2*NREQ-1:0]   req_size;
   logic [15*NREQ-1:0]  req_adr;
   logic [3*NREQ-1:0]   req_sub;
   logic [16*NREQ-1:0]  req_mask;
   logic [256*NREQ-1:0] req_data;
   logic [255:0]        req_rdata;
   logic                command, busy, wr, pending, err, mem_dv;
   logic [1:0]          csize;
   logic [14:0]         adr;
   logic [2:0]          sub;
   logic [15:0]         mask;
   logic [255:0]        dout, mem_data;

   // Requester-side stimulus state (one pending command per requester).
   bit           s_v    [NREQ];
   bit           s_lock [NREQ];
   logic [1:0]   s_size [NREQ];
   bit           s_wr   [NREQ];
   logic [14:0]  s_adr  [NREQ];
   logic [2:0]   s_sub  [NREQ];
   logic [15:0]  s_mask [NREQ];
   logic [255:0] s_data [NREQ];

   // Reference model state.
   int m_rr = 0;
   bit m_lv = 1'b0;
   int m_lo = 0;
   int m_q[$];
   bit m_err = 1'b0;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   gpu_mem_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH), .TAG_AW(2)) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_reqCommand        (req_cmd),
      .o_reqBusy           (req_busy),
      .i_reqLock           (req_lock),
      .i_reqCommandSize    (req_size),
      .i_reqWrite          (req_write),
      .i_reqAdr            (req_adr),
      .i_reqSubadr         (req_sub),
      .i_reqWriteMask      (req_mask),
      .i_reqDataOut        (req_data),
      .o_reqDataInValid    (req_dv),
      .o_reqDataIn         (req_rdata),
      .o_command           (command),
      .i_busy              (busy),
      .o_commandSize       (csize),
      .o_write             (wr),
      .o_adr               (adr),
      .o_subadr            (sub),
      .o_writeMask         (mask),
      .o_dataOut           (dout),
      .i_dataIn            (mem_data),
      .i_dataInValid       (mem_dv),
      .o_readPending       (pending),
      .o_errUnexpectedData (err)
   );

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic bit chance(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input int p_req, input int p_busy, input int p_ret,
                       input int p_lock, input int p_unexp, input bit do_rst);
      int                win;
      bit                full, xfer;
      bit                elig [NREQ];
      logic [NREQ-1:0]   e_busy, e_strobe;
      logic [292:0]      e_fields;
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
         if (s_lock[k] && !s_v[k] && chance(30)) s_lock[k] = 1'b0;
         if (!s_v[k] && chance(p_req)) begin
            s_v[k]    = 1'b1;
            s_size[k] = 2'($urandom_range(1));
            s_wr[k]   = 1'($urandom_range(1));
            s_adr[k]  = 15'($urandom);
            s_sub[k]  = 3'($urandom);
            s_mask[k] = 16'($urandom);
            s_data[k] = rand256();
            s_lock[k] = chance(p_lock);
         end
         req_cmd[k]            = s_v[k];
         req_lock[k]           = s_lock[k];
         req_write[k]          = s_wr[k];
         req_size[2*k +: 2]    = s_size[k];
         req_adr[15*k +: 15]   = s_adr[k];
         req_sub[3*k +: 3]     = s_sub[k];
         req_mask[16*k +: 16]  = s_mask[k];
         req_data[256*k +: 256] = s_data[k];
      end
      rst      = do_rst;
      busy     = chance(p_busy);
      mem_dv   = (m_q.size() > 0) ? chance(p_ret) : chance(p_unexp);
      mem_data = rand256();
      #1;

      // A return pulse frees its owner slot for a read in the same cycle.
      full = (m_q.size() == TAG_DEPTH) && !mem_dv;
      for (int k = 0; k < NREQ; k++) elig[k] = s_v[k] && (s_wr[k] || !full);
      win = -1;
      if (m_lv) begin
         if (elig[m_lo]) win = m_lo;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (win < 0 && elig[(m_rr + i) % NREQ]) win = (m_rr + i) % NREQ;
      end
      if (do_rst) win = -1;

      e_busy   = '1;
      e_fields = '0;
      e_strobe = '0;
      if (win >= 0) begin
         if (!busy) e_busy[win] = 1'b0;
         e_fields = {s_size[win], s_wr[win], s_adr[win], s_sub[win], s_mask[win], s_data[win]};
      end
      if (!do_rst && mem_dv && m_q.size() > 0) e_strobe[m_q[0]] = 1'b1;

      check("command", 512'(command), 512'(win >= 0));
      check("req_busy", 512'(req_busy), 512'(e_busy));
      check("cmd_fields", 512'({csize, wr, adr, sub, mask, dout}), 512'(e_fields));
      check("rd_strobe", 512'(req_dv), 512'(e_strobe));
      check("rd_data", 512'(req_rdata), do_rst ? 512'(0) : 512'(mem_data));
      check("read_pending", 512'(pending), 512'(!do_rst && m_q.size() > 0));
      check("err_unexp", 512'(err), 512'(!do_rst && m_err));

      if (do_rst) begin
         m_rr  = 0;
         m_lv  = 1'b0;
         m_lo  = 0;
         m_err = 1'b0;
         m_q.delete();
      end else begin
         xfer = (win >= 0) && !busy;
         if (mem_dv) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
         end
         if (xfer) begin
            if (!s_wr[win]) m_q.push_back(win);
            m_rr    = (win + 1) % NREQ;
            m_lv    = s_lock[win];
            m_lo    = win;
            s_v[win] = 1'b0;
         end else if (m_lv && !s_lock[m_lo]) begin
            m_lv = 1'b0;
         end
      end
      cyc++;
   endtask

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         s_v[k]    = 1'b0;
         s_lock[k] = 1'b0;
         s_size[k] = '0;
         s_wr[k]   = 1'b0;
         s_adr[k]  = '0;
         s_sub[k]  = '0;
         s_mask[k] = '0;
         s_data[k] = '0;
      end
      rst = 1'b1;
      repeat (3)   step(60, 25, 40, 20, 0, 1'b1);
      repeat (400) step(60, 25, 40, 20, 0, 1'b0);
      // Rare returns: owner FIFO fills, reads stall while writes pass.
      repeat (300) step(70, 10, 5, 10, 0, 1'b0);
      // Heavy locking.
      repeat (300) step(80, 20, 40, 70, 0, 1'b0);
      // Returns with nothing outstanding set the sticky error.
      repeat (200) step(50, 20, 30, 20, 8, 1'b0);
      repeat (2)   step(60, 20, 30, 20, 0, 1'b1);
      repeat (300) step(60, 25, 40, 20, 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
